dbg_csr_access: RTL and testbench
=================================

DBG_CSR_ACCESS -- requirements
Module: dbg_csr_access

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-002 The block SHALL have parameter REGNO_WIDTH, default 16, meaning abstract-command regno width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles to wait for a CSR acknowledge (range 1..255).
REQ-004 The block SHALL have the following ports; clock and reset come first; the block has one clock, and its reset is synchronous and active-high:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- valid_reg_access  in  1  access request pulse from the debug module
- wr1_rd0  in  1  1 = write, 0 = read
- regno  in  REGNO_WIDTH  abstract register number
- write_data  in  DATA_WIDTH  write payload
- read_data_valid  out  1  one-cycle read-complete pulse
- read_data  out  DATA_WIDTH  read result, valid with read_data_valid
- cmd_err  out  1  one-cycle error pulse
- busy  out  1  access in progress
- core_halted  in  1  core is in debug-halt
- dbg_csr_req  out  1  CSR access request, held until ack or timeout
- dbg_csr_we  out  1  CSR write enable
- dbg_csr_addr  out  12  CSR address
- dbg_csr_wdata  out  DATA_WIDTH  CSR write data
- csr_dbg_ack  in  1  CSR access complete
- csr_dbg_rdata  in  DATA_WIDTH  CSR read data, valid with ack
- dbg_gpr_we  out  1  GPR write pulse
- dbg_gpr_addr  out  5  GPR index
- dbg_gpr_wdata  out  DATA_WIDTH  GPR write data
- gpr_rdata  in  DATA_WIDTH  combinational GPR read data for dbg_gpr_addr

Function
REQ-005 The block SHALL decode regno as follows: 0x0000-0x0FFF = CSR (address regno[11:0]); 0x1000-0x101F = GPR (index regno[4:0]); any other value = invalid.
REQ-006 The block SHALL use a state machine with states IDLE, CSR_WAIT and RESP; busy SHALL be 1 in every state except IDLE.
REQ-007 In IDLE, when valid_reg_access=1 and core_halted=0 or regno is invalid, the block SHALL go to RESP, pulse cmd_err in the next cycle, and, for a read, pulse read_data_valid with read_data=0 in that same cycle.
REQ-008 For a GPR read accepted at cycle N, dbg_gpr_addr SHALL be driven combinationally from regno during cycle N, gpr_rdata SHALL be sampled at N, and read_data_valid SHALL be 1 at N+1.
REQ-009 For a GPR write accepted at cycle N, dbg_gpr_we SHALL pulse for exactly one cycle at N+1, with dbg_gpr_addr and dbg_gpr_wdata registered.
REQ-010 For a CSR access accepted at cycle N, the block SHALL go to CSR_WAIT and hold dbg_csr_req=1 from N+1, with dbg_csr_we, dbg_csr_addr and dbg_csr_wdata registered and stable until the request drops.
REQ-011 In CSR_WAIT, csr_dbg_ack=1 at cycle M SHALL drop dbg_csr_req at M+1; for a read, read_data SHALL be csr_dbg_rdata and read_data_valid SHALL be 1 at M+1.
REQ-012 The 8-bit wait counter SHALL clear on entry to CSR_WAIT and increment each cycle that ack=0; when it reaches TIMEOUT_CYCLES, the block SHALL drop the request and pulse cmd_err, plus read_data_valid with data 0 for a read.
REQ-013 If ack arrives in the same cycle as the timeout, ack SHALL win and no error SHALL be flagged.
REQ-014 From RESP, the block SHALL return to IDLE after one cycle; GPR accesses SHALL use RESP as their single busy cycle.
REQ-015 A valid_reg_access arriving while busy=1 SHALL be dropped without any side effect except a cmd_err pulse one cycle later.
REQ-016 read_data_valid, cmd_err and dbg_gpr_we SHALL each be single-cycle pulses; read_data SHALL hold its value until the next response.

Reset
REQ-017 While sys_rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter, with every output 0 (read_data=0, busy=0, dbg_csr_req=0).
REQ-018 A reset during CSR_WAIT SHALL drop dbg_csr_req at the next edge and SHALL NOT produce any response or error pulse.

Configuration
REQ-019 With macro DBG_GPR_ACCESS_EN defined, the block SHALL support GPR access per REQ-008/009.
REQ-020 Without DBG_GPR_ACCESS_EN, the GPR regno range SHALL be treated as invalid per REQ-007, dbg_gpr_we SHALL be tied to 0, and dbg_gpr_addr and dbg_gpr_wdata SHALL be tied to 0.

Verification
REQ-021 Halted core, read regno=0x1005, gpr_rdata=0xDEADBEEF -> read_data_valid=1 with 0xDEADBEEF one cycle later, cmd_err=0.
REQ-022 Halted core, write regno=0x0341 with 0x80000000, ack after 3 cycles -> dbg_csr_req held 3 cycles, we=1, addr=0x341; no read_data_valid.
REQ-023 Read regno=0x0300 with ack never asserted and TIMEOUT_CYCLES=16 -> request drops after 16 cycles; cmd_err and read_data_valid pulse with data 0.
REQ-024 Read regno=0x2000, or core_halted=0 -> cmd_err and read_data_valid with 0 one cycle later; no CSR or GPR strobe.
REQ-025 Second valid_reg_access during CSR_WAIT -> dropped, cmd_err pulse, and the first access completes normally.
REQ-026 sys_rst asserted in CSR_WAIT -> next cycle dbg_csr_req=0, busy=0, no response; build without DBG_GPR_ACCESS_EN and read 0x1001 -> cmd_err.

Source files
------------

// File: rtl/dbg_csr_access.sv
// Debug-module abstract register access bridge: routes regno reads/writes to the CSR port or the GPR port.
// Optional GPR access is enabled by defining DBG_GPR_ACCESS_EN; without it the GPR range decodes as invalid.
module dbg_csr_access #(
  parameter int DATA_WIDTH     = 32,
  parameter int REGNO_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   valid_reg_access,
  input  logic                   wr1_rd0,
  input  logic [REGNO_WIDTH-1:0] regno,
  input  logic [DATA_WIDTH-1:0]  write_data,
  output logic                   read_data_valid,
  output logic [DATA_WIDTH-1:0]  read_data,
  output logic                   cmd_err,
  output logic                   busy,
  input  logic                   core_halted,
  output logic                   dbg_csr_req,
  output logic                   dbg_csr_we,
  output logic [11:0]            dbg_csr_addr,
  output logic [DATA_WIDTH-1:0]  dbg_csr_wdata,
  input  logic                   csr_dbg_ack,
  input  logic [DATA_WIDTH-1:0]  csr_dbg_rdata,
  output logic                   dbg_gpr_we,
  output logic [4:0]             dbg_gpr_addr,
  output logic [DATA_WIDTH-1:0]  dbg_gpr_wdata,
  input  logic [DATA_WIDTH-1:0]  gpr_rdata
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CSR_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP     = 2'd2;
  localparam logic [7:0] TIMEOUT_LAST_C = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_r;
  logic [7:0]            wait_cnt_r;
  logic                  is_read_r;
  logic                  rdv_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  err_r;
  logic                  busy_r;
  logic                  csr_req_r;
  logic                  csr_we_r;
  logic [11:0]           csr_addr_r;
  logic [DATA_WIDTH-1:0] csr_wdata_r;
  logic                  gpr_we_r;
  logic [4:0]            gpr_addr_r;
  logic [DATA_WIDTH-1:0] gpr_wdata_r;
  logic                  is_csr_s;
  logic                  is_gpr_s;

  assign is_csr_s = (regno >> 12) == {REGNO_WIDTH{1'b0}};

`ifdef DBG_GPR_ACCESS_EN
  assign is_gpr_s = (regno >> 5) == REGNO_WIDTH'(12'h080);
  // Address leads combinationally in IDLE so gpr_rdata can be captured on the accepting edge.
  assign dbg_gpr_addr  = (state_r != ST_IDLE) ? gpr_addr_r :
                         (valid_reg_access && is_gpr_s && !sys_rst) ? regno[4:0] : 5'd0;
  assign dbg_gpr_we    = gpr_we_r;
  assign dbg_gpr_wdata = gpr_wdata_r;
`else
  logic unused_gpr_s;
  assign is_gpr_s      = 1'b0;
  assign dbg_gpr_addr  = 5'd0;
  assign dbg_gpr_we    = 1'b0;
  assign dbg_gpr_wdata = {DATA_WIDTH{1'b0}};
  assign unused_gpr_s  = ^{gpr_we_r, gpr_addr_r, gpr_wdata_r};
`endif

  // Access FSM: decode, CSR handshake with timeout, and single-cycle response pulses.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 8'd0;
      is_read_r   <= 1'b0;
      rdv_r       <= 1'b0;
      rd_data_r   <= {DATA_WIDTH{1'b0}};
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      csr_req_r   <= 1'b0;
      csr_we_r    <= 1'b0;
      csr_addr_r  <= 12'd0;
      csr_wdata_r <= {DATA_WIDTH{1'b0}};
      gpr_we_r    <= 1'b0;
      gpr_addr_r  <= 5'd0;
      gpr_wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rdv_r    <= 1'b0;
      err_r    <= 1'b0;
      gpr_we_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid_reg_access) begin
            is_read_r <= ~wr1_rd0;
            busy_r    <= 1'b1;
            if (!core_halted || !(is_csr_s || is_gpr_s)) begin
              state_r <= ST_RESP;
              err_r   <= 1'b1;
              if (!wr1_rd0) begin
                rdv_r     <= 1'b1;
                rd_data_r <= {DATA_WIDTH{1'b0}};
              end
            end else if (is_csr_s) begin
              state_r     <= ST_CSR_WAIT;
              wait_cnt_r  <= 8'd0;
              csr_req_r   <= 1'b1;
              csr_we_r    <= wr1_rd0;
              csr_addr_r  <= regno[11:0];
              csr_wdata_r <= write_data;
            end else begin
              state_r    <= ST_RESP;
              gpr_addr_r <= regno[4:0];
              if (wr1_rd0) begin
                gpr_we_r    <= 1'b1;
                gpr_wdata_r <= write_data;
              end else begin
                rdv_r     <= 1'b1;
                rd_data_r <= gpr_rdata;
              end
            end
          end
        end
        ST_CSR_WAIT: begin
          err_r <= valid_reg_access;
          // Ack is tested first so an ack on the final wait cycle beats the timeout.
          if (csr_dbg_ack) begin
            state_r   <= ST_RESP;
            csr_req_r <= 1'b0;
            if (is_read_r) begin
              rdv_r     <= 1'b1;
              rd_data_r <= csr_dbg_rdata;
            end
          end else if (wait_cnt_r == TIMEOUT_LAST_C) begin
            state_r   <= ST_RESP;
            csr_req_r <= 1'b0;
            err_r     <= 1'b1;
            if (is_read_r) begin
              rdv_r     <= 1'b1;
              rd_data_r <= {DATA_WIDTH{1'b0}};
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end
        ST_RESP: begin
          err_r   <= valid_reg_access;
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          csr_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign read_data_valid = rdv_r;
  assign read_data       = rd_data_r;
  assign cmd_err         = err_r;
  assign busy            = busy_r;
  assign dbg_csr_req     = csr_req_r;
  assign dbg_csr_we      = csr_we_r;
  assign dbg_csr_addr    = csr_addr_r;
  assign dbg_csr_wdata   = csr_wdata_r;

endmodule

// File: tb/tb_dbg_csr_access.sv
// Scoreboard bench for dbg_csr_access: expected responses are queued at stimulus time and matched on output pulses.
module tb_dbg_csr_access;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        valid_reg_access = 1'b0;
  logic        wr1_rd0 = 1'b0;
  logic [15:0] regno = 16'h0000;
  logic [31:0] write_data = 32'h0;
  logic        read_data_valid;
  logic [31:0] read_data;
  logic        cmd_err;
  logic        busy;
  logic        core_halted = 1'b1;
  logic        dbg_csr_req;
  logic        dbg_csr_we;
  logic [11:0] dbg_csr_addr;
  logic [31:0] dbg_csr_wdata;
  logic        csr_dbg_ack = 1'b0;
  logic [31:0] csr_dbg_rdata = 32'h0;
  logic        dbg_gpr_we;
  logic [4:0]  dbg_gpr_addr;
  logic [31:0] dbg_gpr_wdata;
  logic [31:0] gpr_rdata = 32'h0;

  typedef struct packed {
    logic        rdv;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   req_cycles = 0;

  dbg_csr_access #(.DATA_WIDTH(32), .REGNO_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .valid_reg_access(valid_reg_access), .wr1_rd0(wr1_rd0), .regno(regno),
    .write_data(write_data), .read_data_valid(read_data_valid), .read_data(read_data),
    .cmd_err(cmd_err), .busy(busy), .core_halted(core_halted),
    .dbg_csr_req(dbg_csr_req), .dbg_csr_we(dbg_csr_we), .dbg_csr_addr(dbg_csr_addr),
    .dbg_csr_wdata(dbg_csr_wdata), .csr_dbg_ack(csr_dbg_ack), .csr_dbg_rdata(csr_dbg_rdata),
    .dbg_gpr_we(dbg_gpr_we), .dbg_gpr_addr(dbg_gpr_addr), .dbg_gpr_wdata(dbg_gpr_wdata),
    .gpr_rdata(gpr_rdata)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic rdv, input logic err, input logic [31:0] data);
    rsp_t e;
    e.rdv  = rdv;
    e.err  = err;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic access(input logic wr, input logic [15:0] rn, input logic [31:0] wd);
    valid_reg_access = 1'b1;
    wr1_rd0          = wr;
    regno            = rn;
    write_data       = wd;
  endtask

  // Response monitor: every read_data_valid/cmd_err pulse must match the oldest queued expectation.
  always @(negedge sys_clk) begin
    rsp_t e;
    if (!sys_rst) begin
      if (dbg_csr_req) req_cycles++;
      if (read_data_valid || cmd_err) begin
        if (sb_q.size() == 0) begin
          chk("spurious_rsp", {62'd0, read_data_valid, cmd_err}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_rdv", {63'd0, read_data_valid}, {63'd0, e.rdv});
          chk("rsp_err", {63'd0, cmd_err}, {63'd0, e.err});
          if (e.rdv) chk("rsp_data", {32'd0, read_data}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    // Reset state
    step();
    step();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_req", {63'd0, dbg_csr_req}, 64'd0);
    chk("rst_rdata", {32'd0, read_data}, 64'd0);
    chk("rst_pulses", {61'd0, read_data_valid, cmd_err, dbg_gpr_we}, 64'd0);
    chk("rst_gpr_addr", {59'd0, dbg_gpr_addr}, 64'd0);
    sys_rst = 1'b0;
    step();

    // Invalid regno read
    access(1'b0, 16'h2000, 32'h0);
    push(1'b1, 1'b1, 32'h0);
    step();
    valid_reg_access = 1'b0;
    chk("inv_err", {63'd0, cmd_err}, 64'd1);
    chk("inv_rdv", {63'd0, read_data_valid}, 64'd1);
    chk("inv_busy", {63'd0, busy}, 64'd1);
    chk("inv_strobes", {62'd0, dbg_csr_req, dbg_gpr_we}, 64'd0);
    step();
    chk("inv_idle", {63'd0, busy}, 64'd0);

    // Core not halted: CSR write rejected
    core_halted = 1'b0;
    access(1'b1, 16'h0341, 32'h1);
    push(1'b0, 1'b1, 32'h0);
    step();
    valid_reg_access = 1'b0;
    core_halted = 1'b1;
    chk("nh_err", {63'd0, cmd_err}, 64'd1);
    chk("nh_rdv", {63'd0, read_data_valid}, 64'd0);
    chk("nh_req", {63'd0, dbg_csr_req}, 64'd0);
    step();
    step();

`ifdef DBG_GPR_ACCESS_EN
    // GPR read then write
    access(1'b0, 16'h1005, 32'h0);
    gpr_rdata = 32'hDEADBEEF;
    push(1'b1, 1'b0, 32'hDEADBEEF);
    #1;
    chk("gpr_addr_comb", {59'd0, dbg_gpr_addr}, 64'd5);
    step();
    valid_reg_access = 1'b0;
    gpr_rdata = 32'h0;
    chk("gpr_rd_rdv", {63'd0, read_data_valid}, 64'd1);
    chk("gpr_rd_data", {32'd0, read_data}, 64'hDEADBEEF);
    chk("gpr_rd_err", {63'd0, cmd_err}, 64'd0);
    step();
    access(1'b1, 16'h101F, 32'h12345678);
    step();
    valid_reg_access = 1'b0;
    chk("gpr_we", {63'd0, dbg_gpr_we}, 64'd1);
    chk("gpr_wr_addr", {59'd0, dbg_gpr_addr}, 64'd31);
    chk("gpr_wdata", {32'd0, dbg_gpr_wdata}, 64'h12345678);
    step();
    chk("gpr_we_pulse", {63'd0, dbg_gpr_we}, 64'd0);
    chk("gpr_idle", {63'd0, busy}, 64'd0);
`else
    // GPR range is invalid in this build
    access(1'b0, 16'h1001, 32'h0);
    push(1'b1, 1'b1, 32'h0);
    step();
    valid_reg_access = 1'b0;
    chk("nogpr_err", {63'd0, cmd_err}, 64'd1);
    chk("nogpr_we", {63'd0, dbg_gpr_we}, 64'd0);
    step();
`endif
    step();

    // CSR write, ack on third request cycle
    req_cycles = 0;
    access(1'b1, 16'h0341, 32'h80000000);
    step();
    valid_reg_access = 1'b0;
    chk("csrw_req", {63'd0, dbg_csr_req}, 64'd1);
    chk("csrw_we", {63'd0, dbg_csr_we}, 64'd1);
    chk("csrw_addr", {52'd0, dbg_csr_addr}, 64'h341);
    chk("csrw_wdata", {32'd0, dbg_csr_wdata}, 64'h80000000);
    step();
    step();
    csr_dbg_ack = 1'b1;
    step();
    csr_dbg_ack = 1'b0;
    chk("csrw_req_drop", {63'd0, dbg_csr_req}, 64'd0);
    chk("csrw_req_cycles", 64'(req_cycles), 64'd3);
    chk("csrw_no_rdv", {63'd0, read_data_valid}, 64'd0);
    step();
    step();

    // CSR read with a second access dropped while waiting
    access(1'b0, 16'h0F12, 32'h0);
    step();
    access(1'b1, 16'h0001, 32'hFFFFFFFF);
    push(1'b0, 1'b1, 32'h0);
    step();
    valid_reg_access = 1'b0;
    chk("busy_err", {63'd0, cmd_err}, 64'd1);
    chk("busy_keep_addr", {52'd0, dbg_csr_addr}, 64'hF12);
    chk("busy_keep_we", {63'd0, dbg_csr_we}, 64'd0);
    csr_dbg_ack = 1'b1;
    csr_dbg_rdata = 32'hCAFEF00D;
    push(1'b1, 1'b0, 32'hCAFEF00D);
    step();
    csr_dbg_ack = 1'b0;
    csr_dbg_rdata = 32'h0;
    chk("csrr_rdv", {63'd0, read_data_valid}, 64'd1);
    chk("csrr_data", {32'd0, read_data}, 64'hCAFEF00D);
    step();
    chk("csrr_hold", {32'd0, read_data}, 64'hCAFEF00D);
    step();

    // CSR read timeout
    req_cycles = 0;
    access(1'b0, 16'h0300, 32'h0);
    push(1'b1, 1'b1, 32'h0);
    step();
    valid_reg_access = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("to_req_held", {63'd0, dbg_csr_req}, 64'd1);
    step();
    chk("to_req_drop", {63'd0, dbg_csr_req}, 64'd0);
    chk("to_err", {63'd0, cmd_err}, 64'd1);
    chk("to_rdv", {63'd0, read_data_valid}, 64'd1);
    chk("to_data", {32'd0, read_data}, 64'd0);
    chk("to_cycles", 64'(req_cycles), 64'd16);
    step();
    step();

    // Ack on the last wait cycle beats the timeout
    access(1'b0, 16'h0301, 32'h0);
    step();
    valid_reg_access = 1'b0;
    for (int i = 0; i < 15; i++) step();
    csr_dbg_ack = 1'b1;
    csr_dbg_rdata = 32'h55AA55AA;
    push(1'b1, 1'b0, 32'h55AA55AA);
    step();
    csr_dbg_ack = 1'b0;
    chk("race_err", {63'd0, cmd_err}, 64'd0);
    chk("race_data", {32'd0, read_data}, 64'h55AA55AA);
    step();
    step();

    // Reset while waiting for ack
    access(1'b0, 16'h0123, 32'h0);
    step();
    valid_reg_access = 1'b0;
    step();
    sys_rst = 1'b1;
    step();
    chk("rstw_req", {63'd0, dbg_csr_req}, 64'd0);
    chk("rstw_busy", {63'd0, busy}, 64'd0);
    chk("rstw_pulses", {62'd0, read_data_valid, cmd_err}, 64'd0);
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) step();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
